// File: rtl/clb4.sv
// 4-bit carry lookahead block: carries plus group propagate/generate
// computed as flat sum-of-products from per-bit p/g and carry-in.
module clb4 (
   input  logic [3:0] p,
   input  logic [3:0] g,
   input  logic       ci,
   output logic       c1,
   output logic       c2,
   output logic       c3,
   output logic       co,
   output logic       pg,
   output logic       gg
);

   assign c1 = g[0] | (p[0] & ci);
   assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
   assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

   // Group terms exclude ci so a wider adder can cascade them.
   assign pg = p[3] & p[2] & p[1] & p[0];
   assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla4.sv
// 4-bit carry lookahead adder with combinational sum/carry outputs and
// a registered copy of the result.
module cla4 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co,
   output logic       pg,
   output logic       gg,
   output logic [3:0] s_q,
   output logic       co_q
);

   localparam int unsigned W = 4;

   logic [W-1:0] p;
   logic [W-1:0] g;
   logic [W-1:0] c;
   logic         c1, c2, c3;

   assign p = a ^ b;
   assign g = a & b;

   clb4 u_clb4 (
      .p  (p),
      .g  (g),
      .ci (ci),
      .c1 (c1),
      .c2 (c2),
      .c3 (c3),
      .co (co),
      .pg (pg),
      .gg (gg)
   );

   assign c = {c3, c2, c1, ci};
   assign s = p ^ c;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_q  <= '0;
         co_q <= 1'b0;
      end else begin
         s_q  <= s;
         co_q <= co;
      end
   end

endmodule

// File: tb/tb_cla4.sv
// Directed and exhaustive checks of cla4: combinational sum/carry/group
// terms, plus the registered path and its asynchronous reset.
module tb_cla4;

   logic       clk;
   logic       reset_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       ci;
   logic [3:0] s;
   logic       co;
   logic       pg;
   logic       gg;
   logic [3:0] s_q;
   logic       co_q;

   int unsigned total;
   int unsigned bad;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       ci;
      logic [3:0] s;
      logic       co;
      logic       pg;
      logic       gg;
   } vec_t;

   vec_t vecs [12];

   cla4 dut (
      .clk     (clk),
      .reset_n (reset_n),
      .a       (a),
      .b       (b),
      .ci      (ci),
      .s       (s),
      .co      (co),
      .pg      (pg),
      .gg      (gg),
      .s_q     (s_q),
      .co_q    (co_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   initial begin
      logic [4:0] sum;
      logic       exp_pg;
      logic       exp_gg;
      total   = 0;
      bad     = 0;
      reset_n = 1'b0;
      a       = '0;
      b       = '0;
      ci      = 1'b0;

      //            a      b      ci    s      co    pg    gg
      vecs[0]  = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{4'h7, 4'h9, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{4'h5, 4'h5, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{4'h4, 4'h7, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{4'hF, 4'hF, 1'b0, 4'hE, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{4'hA, 4'h5, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};

      // Register held clear while reset is low, even across clock edges.
      repeat (2) @(posedge clk);
      #1;
      chk("reset_s_q", 32'(s_q), 32'h0);
      chk("reset_co_q", 32'(co_q), 32'h0);

      // Combinational vectors work with reset low.
      for (int i = 0; i < 12; i++) begin
         a  = vecs[i].a;
         b  = vecs[i].b;
         ci = vecs[i].ci;
         #1;
         chk($sformatf("vec%0d_s", i), 32'(s), 32'(vecs[i].s));
         chk($sformatf("vec%0d_co", i), 32'(co), 32'(vecs[i].co));
         chk($sformatf("vec%0d_pg", i), 32'(pg), 32'(vecs[i].pg));
         chk($sformatf("vec%0d_gg", i), 32'(gg), 32'(vecs[i].gg));
      end
      chk("reset_hold_s_q", 32'(s_q), 32'h0);

      // Exhaustive sweep against an arithmetic model.
      for (int i = 0; i < 512; i++) begin
         logic [8:0] idx;
         idx = 9'(i);
         a   = idx[3:0];
         b   = idx[7:4];
         ci  = idx[8];
         #1;
         sum    = 5'(a) + 5'(b) + 5'(ci);
         exp_pg = ((a ^ b) == 4'hF);
         exp_gg = ((5'(a) + 5'(b)) >= 5'd16);
         chk($sformatf("sweep_a%0h_b%0h_ci%0d", a, b, ci),
             32'({co, s, pg, gg}), 32'({sum, exp_pg, exp_gg}));
      end

      // Release reset between edges, then capture 3+5.
      @(negedge clk);
      reset_n = 1'b1;
      a  = 4'h3;
      b  = 4'h5;
      ci = 1'b0;
      @(posedge clk);
      #1;
      chk("cap1_s_q", 32'(s_q), 32'h8);
      chk("cap1_co_q", 32'(co_q), 32'h0);

      // New inputs show on s at once but on s_q only after the next edge.
      a = 4'h7;
      b = 4'h9;
      #1;
      chk("lat_s", 32'(s), 32'h0);
      chk("lat_s_q_held", 32'(s_q), 32'h8);
      @(posedge clk);
      #1;
      chk("cap2_s_q", 32'(s_q), 32'h0);
      chk("cap2_co_q", 32'(co_q), 32'h1);

      a = 4'h3;
      b = 4'h5;
      @(posedge clk);
      #1;
      chk("cap3_s_q", 32'(s_q), 32'h8);

      // Asynchronous reset mid-cycle clears only the register.
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("async_s_q", 32'(s_q), 32'h0);
      chk("async_co_q", 32'(co_q), 32'h0);
      chk("async_s", 32'(s), 32'h8);
      chk("async_co", 32'(co), 32'h0);
      a = 4'hF;
      b = 4'hF;
      ci = 1'b1;
      @(posedge clk);
      #1;
      chk("inrst_s_q", 32'(s_q), 32'h0);
      chk("inrst_co_q", 32'(co_q), 32'h0);
      chk("inrst_s", 32'(s), 32'hF);

      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rel_s_q", 32'(s_q), 32'h0);
      @(posedge clk);
      #1;
      chk("first_s_q", 32'(s_q), 32'hF);
      chk("first_co_q", 32'(co_q), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cla4.md
CLA4 -- requirements
Module: cla4

Interface
REQ-001 Parameters: none; the operand width is fixed at 4 bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named clk and reset_n.
REQ-003 clk  input  1  rising-edge clock for the result register only.
REQ-004 reset_n  input  1  asynchronous, active-low reset of the result register.
REQ-005 a  input  4  addend A, unsigned.
REQ-006 b  input  4  addend B, unsigned.
REQ-007 ci  input  1  carry-in.
REQ-008 s  output  4  combinational sum bits.
REQ-009 co  output  1  combinational carry-out.
REQ-010 pg  output  1  group propagate, for cascading into wider adders.
REQ-011 gg  output  1  group generate, for cascading into wider adders.
REQ-012 s_q  output  4  registered copy of s.
REQ-013 co_q  output  1  registered copy of co.

Function
REQ-014 {co,s} SHALL equal a + b + ci as a 5-bit unsigned sum, combinationally with no clock latency.
REQ-015 Per-bit terms SHALL be p[i] = a[i] XOR b[i] and g[i] = a[i] AND b[i], for i = 0..3.
REQ-016 The carries SHALL be computed in lookahead form, not rippled:
- c1 = g0 | p0&ci
- c2 = g1 | p1&g0 | p1&p0&ci
- c3 = g2 | p2&g1 | p2&p1&g0 | p2&p1&p0&ci
- co = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0 | p3&p2&p1&p0&ci
REQ-017 Sum bits SHALL be s[i] = p[i] XOR c[i], with c0 = ci.
REQ-018 pg SHALL equal p3&p2&p1&p0.
REQ-019 gg SHALL equal g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0.
REQ-020 co SHALL always equal gg | (pg & ci).
REQ-021 Overflow wrap-around: when a + b + ci ≥ 16, s SHALL hold the low 4 bits and co SHALL be 1; no saturation.
REQ-022 At each rising clk edge with reset_n high, s_q and co_q SHALL capture s and co, so they have 1-cycle latency.
REQ-023 The combinational outputs s, co, pg and gg SHALL be unaffected by clk and reset_n.
REQ-024 Input changes SHALL propagate to s and co without storage; no latches are inferred.

Reset
REQ-025 When reset_n goes low, s_q SHALL become 4'b0000 and co_q SHALL become 0 immediately, independent of clk.
REQ-026 While reset_n is low, s_q and co_q SHALL hold 0; the first capture occurs at the first rising clk edge after reset_n goes high.
REQ-027 Reset asserted mid-operation SHALL clear only the register; s and co continue to track the inputs.

Structure
REQ-028 No shared package is required; no typedefs; the width of 4 is a local constant.
REQ-029 The carry lookahead equations (REQ-016, REQ-018, REQ-019) SHALL live in one sub-module, clb4, with inputs p, g, ci and outputs c1, c2, c3, co, pg, gg.
REQ-030 cla4 SHALL contain the per-bit p/g generation, the sum XORs, the clb4 instance and the result register.
REQ-031 The design SHALL be synthesizable, with no delays or initial blocks.

Verification
REQ-032 a=0, b=0, ci=0 -> s=0000, co=0, pg=0, gg=0.
REQ-033 a=0011, b=0101, ci=0 -> s=1000, co=0; a=0111, b=1001, ci=0 -> s=0000, co=1 (wrap).
REQ-034 a=0101, b=0101, ci=1 -> s=1011, co=0; a=0100, b=0111, ci=1 -> s=1100, co=0.
REQ-035 a=1111, b=1111, ci=0 -> s=1110, co=1; same inputs with ci=1 -> s=1111, co=1, gg=1.
REQ-036 a=1010, b=0101, ci toggling 0/1 -> pg=1, gg=0, and {co,s} alternates between 0_1111 and 1_0000.
REQ-037 Registered path:
- Apply a=0011, b=0101, ci=0 and one rising clk edge -> s_q=1000, co_q=0.
- Drop reset_n between clock edges -> s_q=0000 and co_q=0 at once, while s stays 1000.
REQ-038 Exhaustive sweep of all 512 input combinations -> {co,s} equals a+b+ci on every combination.
